// File: rtl/reflet_vga_rect_fill.sv
// Wishbone classic master that fills a screen-clipped rectangle by emitting the
// Y / X / color register writes understood by the VGA pixel slave.
module reflet_vga_rect_fill #(
    parameter int                    bus_size    = 32,
    parameter logic [bus_size-1:0]   x_addr      = 32'h7000_0000,
    parameter logic [bus_size-1:0]   y_addr      = 32'h7000_0004,
    parameter logic [bus_size-1:0]   color_addr  = 32'h7000_0008,
    parameter int                    h_size      = 640,
    parameter int                    v_line      = 480,
    parameter int                    coord_width = 16,
    parameter int                    color_width = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [coord_width-1:0] x_start,
    input  logic [coord_width-1:0] y_start,
    input  logic [coord_width-1:0] width,
    input  logic [coord_width-1:0] height,
    input  logic [color_width-1:0] color_in,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [bus_size-1:0]    wb_adr_o,
    output logic [bus_size-1:0]    wb_dat_o,
    output logic                   wb_we_o,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic [3:0]             wb_tag_o,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic [bus_size-1:0]    wb_dat_i
);

    localparam int cw_ext = coord_width + 1;
    localparam logic [coord_width:0] h_lim = cw_ext'(h_size);
    localparam logic [coord_width:0] v_lim = cw_ext'(v_line);

    typedef enum logic [2:0] {IDLE, WR_Y, WR_X, WR_C, DONE} state_t;

    state_t                 state;
    logic [coord_width-1:0] x_cur;
    logic [coord_width-1:0] y_cur;
    logic [coord_width-1:0] x_first;
    logic [coord_width:0]   x_end;
    logic [coord_width:0]   y_end;
    logic [color_width-1:0] color;

    logic [coord_width:0] x_sum, y_sum, x_lim, y_lim, x_next, y_next;
    logic                 null_cmd;
    logic                 unused_ok;

    // Sums are one bit wider than the operands so a large origin plus size
    // cannot wrap around and defeat the screen clip.
    always_comb begin
        x_sum    = {1'b0, x_start} + {1'b0, width};
        y_sum    = {1'b0, y_start} + {1'b0, height};
        x_lim    = (x_sum > h_lim) ? h_lim : x_sum;
        y_lim    = (y_sum > v_lim) ? v_lim : y_sum;
        x_next   = {1'b0, x_cur} + 1'b1;
        y_next   = {1'b0, y_cur} + 1'b1;
        null_cmd = (width == '0) || (height == '0) ||
                   ({1'b0, x_start} >= h_lim) || ({1'b0, y_start} >= v_lim);
    end

    assign wb_we_o   = wb_cyc_o;
    assign wb_tag_o  = 4'd0;
    assign unused_ok = ^wb_dat_i;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register below samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            x_cur    <= '0;
            y_cur    <= '0;
            x_first  <= '0;
            x_end    <= '0;
            y_end    <= '0;
            color    <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            // cyc is high exactly in the write states; an error beats any ack.
            if (wb_cyc_o && wb_err_i) begin
                state    <= IDLE;
                busy     <= 1'b0;
                error    <= 1'b1;
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            x_cur   <= x_start;
                            y_cur   <= y_start;
                            x_first <= x_start;
                            x_end   <= x_lim;
                            y_end   <= y_lim;
                            color   <= color_in;
                            if (null_cmd) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state    <= WR_Y;
                                busy     <= 1'b1;
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                wb_adr_o <= y_addr;
                                wb_dat_o <= bus_size'(y_start);
                            end
                        end
                    end
                    WR_Y: begin
                        if (wb_ack_i) begin
                            state    <= WR_X;
                            wb_adr_o <= x_addr;
                            wb_dat_o <= bus_size'(x_cur);
                        end
                    end
                    WR_X: begin
                        if (wb_ack_i) begin
                            state    <= WR_C;
                            wb_adr_o <= color_addr;
                            wb_dat_o <= bus_size'(color);
                        end
                    end
                    WR_C: begin
                        if (wb_ack_i) begin
                            if (x_next < x_end) begin
                                state    <= WR_X;
                                x_cur    <= x_cur + 1'b1;
                                wb_adr_o <= x_addr;
                                wb_dat_o <= bus_size'(x_next);
                            end else if (y_next < y_end) begin
                                state    <= WR_Y;
                                y_cur    <= y_cur + 1'b1;
                                x_cur    <= x_first;
                                wb_adr_o <= y_addr;
                                wb_dat_o <= bus_size'(y_next);
                            end else begin
                                state    <= DONE;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                wb_cyc_o <= 1'b0;
                                wb_stb_o <= 1'b0;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reflet_vga_rect_fill.sv
// Scoreboard bench: directed rectangle commands push their expected bus writes,
// a monitor behind a wait-state-capable slave model pops and compares them.
module tb_reflet_vga_rect_fill;

    localparam logic [31:0] x_a = 32'h7000_0000;
    localparam logic [31:0] y_a = 32'h7000_0004;
    localparam logic [31:0] c_a = 32'h7000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] x_start = '0, y_start = '0, width = '0, height = '0;
    logic [23:0] color_in = '0;
    logic        busy, done, error;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [3:0]  wb_tag_o;
    logic        wb_ack_i, wb_err_i;
    logic [31:0] wb_dat_i = '0;

    reflet_vga_rect_fill dut (
        .clk(clk), .reset(reset), .start(start),
        .x_start(x_start), .y_start(y_start), .width(width), .height(height),
        .color_in(color_in), .busy(busy), .done(done), .error(error),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_tag_o(wb_tag_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    xfer_t exp_q[$];
    int    compared = 0;
    int    mismatched = 0;
    int    wait_n = 0;
    bit    err_en = 1'b0;
    int    wcnt = 0;
    int    xfer_cnt = 0;
    int    acks = 0;
    int    fb[int];
    int    last_x = 0, last_y = 0;
    bit    pend = 1'b0;
    logic [31:0] pend_adr = '0, pend_dat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Slave model: combinational ack after wait_n stall cycles; optional
    // error on the 4th transfer of a command, together with ack.
    always_comb begin
        wb_ack_i = wb_cyc_o && wb_stb_o && (wcnt == wait_n);
        wb_err_i = wb_ack_i && err_en && (xfer_cnt == 3);
    end

    always @(posedge clk) begin
        if (reset) begin
            wcnt     <= 0;
            xfer_cnt <= 0;
        end else begin
            if (start && !busy) xfer_cnt <= 0;
            else if (wb_ack_i) xfer_cnt <= xfer_cnt + 1;
            if (wb_cyc_o && wb_stb_o) wcnt <= wb_ack_i ? 0 : wcnt + 1;
            else wcnt <= 0;
        end
    end

    // Monitor: compares completed writes and bus stability during stalls.
    always @(negedge clk) begin
        if (!reset) begin
            if (wb_cyc_o) check("we_eq_cyc", wb_we_o, 1'b1);
            if (pend) begin
                check("stall_cyc_stb", wb_cyc_o && wb_stb_o, 1'b1);
                check("stall_adr", wb_adr_o, pend_adr);
                check("stall_dat", wb_dat_o, pend_dat);
            end
            if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) begin
                acks++;
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer_adr", wb_adr_o, 32'hFFFF_FFFF);
                end else begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    check("xfer_adr", wb_adr_o, e.adr);
                    check("xfer_dat", wb_dat_o, e.dat);
                end
                if (wb_adr_o == x_a) begin
                    check("x_on_screen", wb_dat_o < 640, 1'b1);
                    last_x = int'(wb_dat_o);
                end else if (wb_adr_o == y_a) begin
                    check("y_on_screen", wb_dat_o < 480, 1'b1);
                    last_y = int'(wb_dat_o);
                end else if (wb_adr_o == c_a) begin
                    fb[last_y * 1024 + last_x] = int'(wb_dat_o);
                end
            end
        end
        pend     = !reset && wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i;
        pend_adr = wb_adr_o;
        pend_dat = wb_dat_o;
    end

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        xfer_t e;
        e.adr = a;
        e.dat = d;
        exp_q.push_back(e);
    endtask

    task automatic push_t1(input logic [31:0] c);
        push(y_a, 20); push(x_a, 10); push(c_a, c); push(x_a, 11); push(c_a, c);
        push(y_a, 21); push(x_a, 10); push(c_a, c); push(x_a, 11); push(c_a, c);
    endtask

    task automatic issue(input int x, input int y, input int w, input int h, input int c);
        @(negedge clk);
        x_start  = 16'(x);
        y_start  = 16'(y);
        width    = 16'(w);
        height   = 16'(h);
        color_in = 24'(c);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Returns at the negedge where done or error is seen; cyc_n counts negedges
    // since the capture edge, busy_n those with busy high.
    task automatic wait_end(output int cyc_n, output int busy_n, output bit got_done,
                            output bit got_err);
        cyc_n = 0; busy_n = 0; got_done = 0; got_err = 0;
        for (int i = 1; i <= 2000; i++) begin
            if (busy) busy_n++;
            if (done || error) begin
                got_done = done;
                got_err  = error;
                cyc_n    = i;
                break;
            end
            @(negedge clk);
        end
        if (!got_done && !got_err) check("timeout_waiting_end", 1'b0, 1'b1);
    endtask

    task automatic check_px(input string name, input int x, input int y, input int c);
        int k;
        k = y * 1024 + x;
        check(name, fb.exists(k) ? 32'(fb[k]) : 32'hFFFF_FFFF, 32'(c));
    endtask

    initial begin
        int  cyc_n, busy_n, a0;
        bit  gd, ge, quiet;

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_tag", wb_tag_o, 4'h0);

        // Zero-wait 2x2 fill
        fb.delete();
        push_t1(32'h0012_3456);
        issue(10, 20, 2, 2, 32'h123456);
        wait_end(cyc_n, busy_n, gd, ge);
        check("t1_done", gd, 1'b1);
        check("t1_error", ge, 1'b0);
        check("t1_cycles_to_done", cyc_n, 11);
        check("t1_busy_cycles", busy_n, 10);
        check("t1_cyc_at_done", {wb_cyc_o, busy}, 2'b00);
        @(negedge clk);
        check("t1_done_pulse", done, 1'b0);
        check("t1_queue_left", exp_q.size(), 0);
        check("t1_px_count", fb.num(), 4);
        check_px("t1_px_10_20", 10, 20, 32'h123456);
        check_px("t1_px_11_20", 11, 20, 32'h123456);
        check_px("t1_px_10_21", 10, 21, 32'h123456);
        check_px("t1_px_11_21", 11, 21, 32'h123456);

        // Same command against 3 wait states per transfer
        fb.delete();
        wait_n = 3;
        push_t1(32'h0012_3456);
        issue(10, 20, 2, 2, 32'h123456);
        wait_end(cyc_n, busy_n, gd, ge);
        check("t2_done", gd, 1'b1);
        check("t2_busy_cycles", busy_n, 40);
        check("t2_cycles_to_done", cyc_n, 41);
        check("t2_queue_left", exp_q.size(), 0);
        check("t2_px_count", fb.num(), 4);

        // Clipped at the bottom-right corner
        fb.delete();
        wait_n = 0;
        push(y_a, 479); push(x_a, 638); push(c_a, 32'h00AB_CDEF);
        push(x_a, 639); push(c_a, 32'h00AB_CDEF);
        issue(638, 479, 5, 5, 32'hABCDEF);
        wait_end(cyc_n, busy_n, gd, ge);
        check("t3_done", gd, 1'b1);
        check("t3_busy_cycles", busy_n, 5);
        check("t3_queue_left", exp_q.size(), 0);
        check("t3_px_count", fb.num(), 2);
        check_px("t3_px_639_479", 639, 479, 32'hABCDEF);

        // Null commands: width 0, then origin off screen
        a0 = acks;
        issue(10, 10, 0, 5, 32'h111111);
        check("t4a_done", done, 1'b1);
        check("t4a_busy_cyc", {busy, wb_cyc_o}, 2'b00);
        @(negedge clk);
        check("t4a_after", {done, busy, wb_cyc_o}, 3'b000);
        issue(700, 10, 4, 4, 32'h222222);
        check("t4b_done", done, 1'b1);
        check("t4b_busy_cyc", {busy, wb_cyc_o}, 2'b00);
        @(negedge clk);
        check("t4b_after", {done, busy, wb_cyc_o}, 3'b000);
        check("t4_no_xfers", acks - a0, 0);

        // Error on the 4th transfer, together with ack
        err_en = 1'b1;
        push(y_a, 20); push(x_a, 10); push(c_a, 32'h0012_3456);
        issue(10, 20, 2, 2, 32'h123456);
        wait_end(cyc_n, busy_n, gd, ge);
        check("t5_error", ge, 1'b1);
        check("t5_done", gd, 1'b0);
        check("t5_cycles_to_error", cyc_n, 5);
        check("t5_bus_dropped", {wb_cyc_o, wb_stb_o, busy}, 3'b000);
        @(negedge clk);
        check("t5_error_pulse", {error, done}, 2'b00);
        check("t5_queue_left", exp_q.size(), 0);
        err_en = 1'b0;
        push(y_a, 5); push(x_a, 5); push(c_a, 32'h0000_FF00);
        issue(5, 5, 1, 1, 32'h00FF00);
        wait_end(cyc_n, busy_n, gd, ge);
        check("t5_restart_done", gd, 1'b1);
        check("t5_restart_cycles", cyc_n, 4);

        // Start while busy is ignored
        wait_n = 1;
        a0 = acks;
        push(y_a, 100); push(x_a, 100); push(c_a, 32'h0077_7777);
        push(x_a, 101); push(c_a, 32'h0077_7777);
        issue(100, 100, 2, 1, 32'h777777);
        repeat (3) @(negedge clk);
        x_start = 16'd1; y_start = 16'd1; width = 16'd9; height = 16'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(cyc_n, busy_n, gd, ge);
        check("t6_done", gd, 1'b1);
        check("t6_xfer_count", acks - a0, 5);
        check("t6_queue_left", exp_q.size(), 0);
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy || wb_cyc_o) quiet = 1'b0;
        end
        check("t6_no_second_cmd", quiet, 1'b1);

        // Reset mid-command
        wait_n = 3;
        push(y_a, 0); push(x_a, 0); push(c_a, 32'h0001_0203); push(x_a, 1);
        issue(0, 0, 3, 2, 32'h010203);
        repeat (5) @(negedge clk);
        check("t7_busy_before", {busy, wb_cyc_o}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        check("t7_reset_drop", {wb_cyc_o, wb_stb_o, busy}, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        a0 = acks;
        repeat (10) @(negedge clk);
        check("t7_no_xfers_after", acks - a0, 0);
        check("t7_idle_after", {busy, wb_cyc_o}, 2'b00);
        wait_n = 0;
        push(y_a, 5); push(x_a, 5); push(c_a, 32'h0000_00FF);
        issue(5, 5, 1, 1, 32'h0000FF);
        wait_end(cyc_n, busy_n, gd, ge);
        check("t7_restart_done", gd, 1'b1);
        check("t7_queue_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reflet_vga_rect_fill.md
Name: reflet_VGA_rect_fill

Overview:
- Wishbone classic master directly upstream of the VGA Wishbone pixel slave.
- Accepts a rectangle command (origin, size, color) and emits the X/Y/color register write sequence that plots every pixel of the rectangle.
- Offloads the CPU from per-pixel bus traffic.
- Plotting is clipped to the screen, so no off-screen coordinate is ever written.

Parameters:
- bus_size, 32, Wishbone data/address width.
- x_addr, 32'h70000000, address of the slave X register.
- y_addr, 32'h70000004, address of the slave Y register.
- color_addr, 32'h70000008, address of the slave color register; a write here plots a pixel.
- h_size, 640, visible pixels per line; used for clipping.
- v_line, 480, visible lines; used for clipping.
- coord_width, 16, width of the coordinate and size inputs.
- color_width, 24, width of color_in; zero-extended to bus_size on the bus.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- x_start  in  coord_width  rectangle left column.
- y_start  in  coord_width  rectangle top line.
- width  in  coord_width  columns to fill.
- height  in  coord_width  lines to fill.
- color_in  in  color_width  fill color.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at normal completion or after a null command.
- error  out  1  one-cycle pulse when a command is aborted by wb_err_i.
- wb_adr_o  out  bus_size  bus address.
- wb_dat_o  out  bus_size  write data.
- wb_we_o  out  1  write enable; always equal to wb_cyc_o.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_tag_o  out  4  tied to 0.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.
- wb_dat_i  in  bus_size  ignored.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, done, error, wb_cyc_o, wb_stb_o and wb_we_o are 0; wb_adr_o and wb_dat_o are 0.
  - Reset mid-command drops cyc/stb at the same edge and discards the command.
- Command capture (IDLE with start=1):
  - Latch all inputs.
  - Compute x_end = min(x_start+width, h_size) and y_end = min(y_start+height, v_line) in coord_width+1 bits, so the sum cannot overflow.
  - If width=0, height=0, x_start>=h_size or y_start>=v_line: no bus traffic, go to DONE.
  - Otherwise: busy=1 from the next cycle and go to WR_Y.
- start while busy is ignored. Inputs are not re-sampled mid-command.
- States: IDLE, WR_Y, WR_X, WR_C, DONE.
  - WR_Y: adr=y_addr, dat=current y.
  - WR_X: adr=x_addr, dat=current x.
  - WR_C: adr=color_addr, dat=latched color.
  - In every write state, cyc=stb=we=1.
- Sequence per row: WR_Y, then (WR_X, WR_C) for each column x_start..x_end-1.
- Advance rule: a state advances only on a clock edge with wb_ack_i=1.
  - Without ack, adr, dat, cyc and stb are held indefinitely; there is no timeout.
  - cyc and stb stay high across consecutive transfers, so a zero-wait slave gives one transfer per cycle.
- After WR_C ack:
  - If x+1 < x_end: x++, go to WR_X.
  - Else if y+1 < y_end: y++, x = x_start, go to WR_Y.
  - Else go to DONE.
- DONE: lasts one cycle.
  - done=1, busy=0, cyc=stb=0.
  - Next state is IDLE; start in this cycle is ignored.
- Error: wb_err_i=1 in any write state (takes priority over a simultaneous ack):
  - cyc/stb drop at that edge and busy=0.
  - error pulses for one cycle and the state returns to IDLE.
  - done is not asserted.
- Transfer count for an unclipped command: rows*(1+2*cols). With a zero-wait slave, busy is high for exactly that many cycles.

Test Plan:
- Reset, then start with (10,20) w=2 h=2 color=0x123456 against a zero-wait slave → 10 transfers on consecutive cycles: Y20, X10, C, X11, C, Y21, X10, C, X11, C. done pulses the cycle after the last ack; the slave frame buffer shows 4 pixels = 0x123456.
- Slave inserting 3 wait states per transfer → adr/dat stable while unacked; same sequence; busy lasts 40 cycles.
- x_start=638, y_start=479, w=5, h=5 → clipped to 2 columns × 1 row: Y479, X638, C, X639, C; no coordinate ≥ h_size or v_line appears on the bus.
- width=0, and separately x_start=700 → no cyc assertion; done pulses one cycle after start; busy never rises.
- wb_err_i asserted on the 4th transfer, with wb_ack_i also high → cyc/stb low next cycle, error=1 for one cycle, done stays 0; a fresh start is accepted afterwards.
- reset pulsed mid-command, and start pulsed while busy → reset drops cyc and busy immediately; the start-while-busy is ignored and the transfer count is unchanged.
